// File: rtl/acq_pkg.sv
// acq_pkg
// Shared definitions for the NMR receive acquisition controller:
//   - default widths for the dead-time/record counters, packed I/Q words
//     and the decimation factor
//   - depth of the small output FIFO
//   - state encoding of the acquisition sequencer (also exported on state_o)
package acq_pkg;

   localparam int CNT_W_DEF   = 16;
   localparam int DATA_W_DEF  = 64;
   localparam int DECIM_W_DEF = 8;
   localparam int FIFO_DEPTH  = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_DEAD  = 3'd2,
      ST_ACQ   = 3'd3,
      ST_FLUSH = 3'd4,
      ST_DONE  = 3'd5
   } acq_state_t;

endpackage

// File: rtl/acq_fifo2.sv
// acq_fifo2
// Two-entry registered FIFO that decouples the filtered-word capture from the
// readout stream. The oldest entry always sits in a dedicated head register, so
// the stream data comes straight from a flop and stays put while the consumer
// stalls.
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset (clears contents and count)
//   flush      drop all entries (takes priority over push/pop)
//   push       write push_data when not full
//   push_data  entry to store
//   pop        remove head entry when not empty
//   head       oldest entry
//   full       both entries occupied
//   empty      no entries
module acq_fifo2
   import acq_pkg::*;
#(
   parameter int WIDTH = 2 * DATA_W_DEF + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

   logic [WIDTH-1:0] tail;
   logic [1:0]       count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == 2'd0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Head/tail shift structure: a pop moves tail into head, a push lands in
   // whichever slot is the first free one after any simultaneous pop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= 2'd0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (count == 2'd0) head <= push_data;
               else               tail <= push_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  head <= push_data;
               end else begin
                  head <= tail;
                  tail <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/acq_controller.sv
// acq_controller
// Sequences one NMR receive acquisition: armed by the host, started by the
// end-of-pulse trigger, waits out the ring-down dead time, enables the
// mixer/FIR datapath, keeps one of every decim filtered I/Q words and streams
// a fixed-length record out over valid/ready.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   arm_i, abort_i, trig_i     host arm, abort, pulse-programmer trigger
//   dead_time_i, acq_len_i,
//   decim_i                    record configuration, latched on accepted arm
//   dds_val_o                  datapath enable
//   filter_valid_i, data_i_i,
//   data_q_i                   filtered datapath words
//   m_valid_o, m_ready_i,
//   m_data_o ({Q,I}), m_last_o output record stream
//   busy_o, done_o, overflow_o,
//   state_o                    status and debug
module acq_controller
   import acq_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int DECIM_W = DECIM_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                arm_i,
   input  logic                abort_i,
   input  logic                trig_i,
   input  logic [CNT_W-1:0]    dead_time_i,
   input  logic [CNT_W-1:0]    acq_len_i,
   input  logic [DECIM_W-1:0]  decim_i,
   output logic                dds_val_o,
   input  logic                filter_valid_i,
   input  logic [DATA_W-1:0]   data_i_i,
   input  logic [DATA_W-1:0]   data_q_i,
   output logic                m_valid_o,
   input  logic                m_ready_i,
   output logic [2*DATA_W-1:0] m_data_o,
   output logic                m_last_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                overflow_o,
   output logic [2:0]          state_o
);

   localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
   localparam logic [DECIM_W-1:0] DEC_ONE = DECIM_W'(1);

   acq_state_t         state;
   acq_state_t         state_next;
   logic [CNT_W-1:0]   cfg_dead;
   logic [CNT_W-1:0]   cfg_len;
   logic [DECIM_W-1:0] cfg_decim;
   logic [CNT_W-1:0]   dead_cnt;
   logic [CNT_W-1:0]   kept_cnt;
   logic [DECIM_W-1:0] phase;

   logic accept_arm;
   logic abort_hit;
   logic keep;
   logic last_keep;
   logic fifo_full;
   logic fifo_empty;
   logic fifo_pop;

   // Abort only matters once a record is in progress; in IDLE it is a no-op.
   assign accept_arm = arm_i && (acq_len_i != '0);
   assign abort_hit  = abort_i && (state != ST_IDLE);
   assign keep       = (state == ST_ACQ) && filter_valid_i && (phase == '0) && !abort_hit;
   assign last_keep  = keep && (kept_cnt == cfg_len - CNT_ONE);
   assign fifo_pop   = m_valid_o && m_ready_i;

   // State register plus the registered status outputs, all derived from the
   // upcoming state so they line up with state_o.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         dds_val_o <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         state     <= state_next;
         dds_val_o <= (state_next == ST_ACQ);
         busy_o    <= (state_next != ST_IDLE);
         done_o    <= (state_next == ST_DONE);
      end
   end

   // Next-state logic. A trigger in the arm cycle is ignored because the
   // controller is still in IDLE then; a zero dead time skips DEAD entirely.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (accept_arm) state_next = ST_ARMED;
         ST_ARMED: if (trig_i) state_next = (cfg_dead == '0) ? ST_ACQ : ST_DEAD;
         ST_DEAD:  if (dead_cnt == cfg_dead - CNT_ONE) state_next = ST_ACQ;
         ST_ACQ:   if (last_keep) state_next = ST_FLUSH;
         ST_FLUSH: if (fifo_empty) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
      if (abort_hit) state_next = ST_IDLE;
   end

   // Configuration, counters and the sticky overflow flag. Counters are
   // re-zeroed while ARMED so every record starts from a clean phase; a kept
   // word that finds the FIFO full still counts towards the record length.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cfg_dead   <= '0;
         cfg_len    <= '0;
         cfg_decim  <= '0;
         dead_cnt   <= '0;
         kept_cnt   <= '0;
         phase      <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (state == ST_IDLE && accept_arm) begin
            cfg_dead   <= dead_time_i;
            cfg_len    <= acq_len_i;
            cfg_decim  <= (decim_i == '0) ? DEC_ONE : decim_i;
            overflow_o <= 1'b0;
         end
         if (state == ST_ARMED) begin
            dead_cnt <= '0;
            kept_cnt <= '0;
            phase    <= '0;
         end
         if (state == ST_DEAD) dead_cnt <= dead_cnt + CNT_ONE;
         if (state == ST_ACQ && filter_valid_i)
            phase <= (phase == cfg_decim - DEC_ONE) ? '0 : phase + DEC_ONE;
         if (keep) kept_cnt <= kept_cnt + CNT_ONE;
         if (keep && fifo_full) overflow_o <= 1'b1;
      end
   end

   acq_fifo2 #(
      .WIDTH(2 * DATA_W + 1)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (abort_hit),
      .push     (keep),
      .push_data({last_keep, data_q_i, data_i_i}),
      .pop      (fifo_pop),
      .head     ({m_last_o, m_data_o}),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign m_valid_o = !fifo_empty;
   assign state_o   = state;

endmodule
